mac_acc_block: RTL

- Accumulation stage directly downstream of the MAC multiply block.
- Consumes the combinational product bus C (MAC_INT_WIDTH) and sums a programmable number of products into a wide accumulator.
- Emits the finished sum on a valid/ready output with a sticky overflow flag.
- Provides the registered pipeline boundary after the non-pipelined multiplier.

---
 rtl/mac_acc_block_pkg.sv | 39 +++
 rtl/mac_acc_add.sv | 40 ++++
 rtl/mac_acc_block.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mac_acc_block_pkg.sv
// Shared constants for the MAC accumulation stage: widths, mode codes,
// config bit positions and FSM state encodings.
package mac_acc_block_pkg;

  localparam int MAC_CONF_WIDTH = 3;
  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH;
  localparam int MAC_ACC_WIDTH  = 6 * MAC_MIN_WIDTH;
  localparam int MAC_LEN_WIDTH  = 8;

  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  localparam int MAC_CFG_SAT = 2;

  localparam int MAC_W_SINGLE = 16;
  localparam int MAC_W_DUAL   = 24;
  localparam int MAC_W_QUAD   = 40;

  localparam logic [MAC_LEN_WIDTH-1:0] MAC_LEN_ONE = 8'd1;

  typedef enum logic [1:0] {
    MAC_ACC_IDLE  = 2'd0,
    MAC_ACC_ACCUM = 2'd1,
    MAC_ACC_HOLD  = 2'd2
  } mac_acc_state_e;

  // Number of low product bits kept for a mode; unknown modes keep nothing.
  function automatic int mode_width(input logic [1:0] mode);
    case (mode)
      MAC_SINGLE: mode_width = MAC_W_SINGLE;
      MAC_DUAL:   mode_width = MAC_W_DUAL;
      MAC_QUAD:   mode_width = MAC_W_QUAD;
      default:    mode_width = 0;
    endcase
  endfunction

endpackage

// File: rtl/mac_acc_add.sv
// Combinational masked add: zero-extends and masks the product by mode,
// adds it to the accumulator, reports carry-out and optionally saturates.
module mac_acc_add
  import mac_acc_block_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_WIDTH
) (
  input  logic [ACC_W-1:0]         acc_i,
  input  logic [MAC_INT_WIDTH-1:0] c_i,
  input  logic [1:0]               mode_i,
  input  logic                     sat_i,
  output logic [ACC_W-1:0]         sum_o,
  output logic                     carry_o
);

  logic [ACC_W-1:0] c_ext_s;
  logic [ACC_W-1:0] masked_s;
  logic [ACC_W:0]   sum_w_s;
  int               keep_s;

  assign c_ext_s = ACC_W'(c_i);

  // Keep only the low product bits that belong to the selected mode.
  always_comb begin
    keep_s   = mode_width(mode_i);
    masked_s = {ACC_W{1'b0}};
    for (int i = 0; i < ACC_W; i++) begin
      if (i < keep_s) begin
        masked_s[i] = c_ext_s[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end
  end

  assign sum_w_s = {1'b0, acc_i} + {1'b0, masked_s};
  assign carry_o = sum_w_s[ACC_W];
  assign sum_o   = (carry_o && sat_i) ? {ACC_W{1'b1}} : sum_w_s[ACC_W-1:0];

endmodule

// File: rtl/mac_acc_block.sv
// Accumulation stage after the MAC multiplier: sums a programmable number
// of masked products and presents the result on a valid/ready output.
module mac_acc_block
  import mac_acc_block_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic [MAC_LEN_WIDTH-1:0]  acc_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_INT_WIDTH-1:0]  C,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_ovf
);

  mac_acc_state_e              state_q, state_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [MAC_LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [MAC_LEN_WIDTH-1:0]    len_q, len_d;
  logic [MAC_CONF_WIDTH-1:0]   cfg_q, cfg_d;
  logic                        ovf_q, ovf_d;

  logic                        accept_s;
  logic                        start_s;
  logic [MAC_LEN_WIDTH-1:0]    len_eff_s;
  logic [MAC_LEN_WIDTH-1:0]    cnt_inc_s;
  mac_acc_state_e              win_state_s;
  logic [ACC_W-1:0]            add_acc_s;
  logic [1:0]                  add_mode_s;
  logic                        add_sat_s;
  logic [ACC_W-1:0]            sum_s;
  logic                        carry_s;

  // Input readiness per state; a stalled result blocks new beats.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      MAC_ACC_IDLE:  in_ready = en;
      MAC_ACC_ACCUM: in_ready = en;
      MAC_ACC_HOLD:  in_ready = en & out_ready;
      default:       in_ready = 1'b0;
    endcase
  end

  assign accept_s    = in_valid & in_ready;
  assign start_s     = accept_s & (state_q != MAC_ACC_ACCUM);
  assign len_eff_s   = (acc_len == {MAC_LEN_WIDTH{1'b0}}) ? MAC_LEN_ONE : acc_len;
  assign cnt_inc_s   = cnt_q + MAC_LEN_ONE;
  assign win_state_s = (len_eff_s == MAC_LEN_ONE) ? MAC_ACC_HOLD : MAC_ACC_ACCUM;

  // A new window adds onto zero using the live cfg; otherwise the latched cfg.
  assign add_acc_s  = start_s ? {ACC_W{1'b0}} : acc_q;
  assign add_mode_s = start_s ? cfg[1:0] : cfg_q[1:0];
  assign add_sat_s  = start_s ? cfg[MAC_CFG_SAT] : cfg_q[MAC_CFG_SAT];

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_i   (add_acc_s),
    .c_i     (C),
    .mode_i  (add_mode_s),
    .sat_i   (add_sat_s),
    .sum_o   (sum_s),
    .carry_o (carry_s)
  );

  // Next-state logic; clear overrides everything except reset.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cfg_d   = cfg_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = MAC_ACC_IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {MAC_LEN_WIDTH{1'b0}};
      len_d   = {MAC_LEN_WIDTH{1'b0}};
      cfg_d   = {MAC_CONF_WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        MAC_ACC_IDLE, MAC_ACC_HOLD: begin
          if (start_s) begin
            cfg_d   = cfg;
            len_d   = len_eff_s;
            acc_d   = sum_s;
            cnt_d   = MAC_LEN_ONE;
            ovf_d   = 1'b0;
            state_d = win_state_s;
          end else if (state_q == MAC_ACC_HOLD && out_ready) begin
            state_d = MAC_ACC_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        MAC_ACC_ACCUM: begin
          if (accept_s) begin
            acc_d   = sum_s;
            ovf_d   = ovf_q | carry_s;
            cnt_d   = cnt_inc_s;
            state_d = (cnt_inc_s == len_q) ? MAC_ACC_HOLD : MAC_ACC_ACCUM;
          end else begin
            state_d = MAC_ACC_ACCUM;
          end
        end
        default: state_d = MAC_ACC_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAC_ACC_IDLE;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {MAC_LEN_WIDTH{1'b0}};
      len_q   <= {MAC_LEN_WIDTH{1'b0}};
      cfg_q   <= {MAC_CONF_WIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cfg_q   <= cfg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == MAC_ACC_HOLD);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule
